// File: rtl/cic_pkg.sv
// Shared helpers for the CIC interpolator and decimator.
package cic_pkg;

    // Phase counter width for a rate-change factor (RATE >= 2).
    function automatic int unsigned cic_cnt_width(input int unsigned rate);
        return $clog2(rate);
    endfunction

    // Register width bound INPUT_WIDTH + SECTIONS*ceil(log2(RATE)).
    // This bound comes from the decimator's growth. The interpolator's last
    // integrator grows only by R^(N-1), so it can run narrower.
    function automatic int unsigned cic_min_acc_width(input int unsigned sections,
                                                      input int unsigned rate,
                                                      input int unsigned input_width);
        return input_width + sections * $clog2(rate);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: a modulo-2^AccWidth accumulator advanced on each enable.
module cic_integrator_stage #(
    parameter int unsigned AccWidth = 38
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [AccWidth-1:0] in_i,
    output logic [AccWidth-1:0] acc_o
);

    logic [AccWidth-1:0] acc_q, acc_d;

    // Next accumulator value; wrap-around is intentional and cancelled by the combs.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + in_i;
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_up.sv
// CIC interpolator: low-rate combs, zero-stuffing, high-rate integrators.
module cic_up
    import cic_pkg::*;
#(
    parameter int unsigned SECTIONS     = 3,
    parameter int unsigned RATE         = 400,
    parameter int unsigned INPUT_WIDTH  = 12,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned ACC_WIDTH    = 38,
    parameter int unsigned OUT_SHIFT    = 18
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_enable,
    input  logic signed [INPUT_WIDTH-1:0]  filter_in,
    output logic                           in_strobe,
    output logic signed [OUTPUT_WIDTH-1:0] filter_out,
    output logic                           ce_out
);

    localparam int unsigned CntWidth = cic_cnt_width(RATE);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(RATE - 1);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [CntWidth-1:0]  cur_count_q, cur_count_d;
    logic [ACC_WIDTH-1:0] comb_d_q [SECTIONS];
    logic [ACC_WIDTH-1:0] comb_tap [SECTIONS];
    logic [ACC_WIDTH-1:0] comb_res;
    logic [ACC_WIDTH-1:0] comb_out_q;
    logic [ACC_WIDTH-1:0] integ [SECTIONS+1];
    logic signed [OUTPUT_WIDTH-1:0] filter_out_q;
    logic ce_out_q;
    logic unused_integ_bits;

    // Phase counter: advances once per high-rate enable, wraps at RATE-1.
    always_comb begin
        cur_count_d = cur_count_q;
        if (clk_enable) begin
            cur_count_d = (cur_count_q == CntMax) ? '0 : cur_count_q + CntOne;
        end
    end

    assign in_strobe = clk_enable && (cur_count_q == '0);

    // Comb chain: tap[k] is the input to comb k+1; each stage subtracts its delayed input.
    always_comb begin
        logic [ACC_WIDTH-1:0] acc;
        acc = {{(ACC_WIDTH-INPUT_WIDTH){filter_in[INPUT_WIDTH-1]}}, filter_in};
        for (int k = 0; k < SECTIONS; k++) begin
            comb_tap[k] = acc;
            acc = acc - comb_d_q[k];
        end
        comb_res = acc;
    end

    // State advances: phase counter on enable, comb delays and comb output on in_strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_count_q <= '0;
            comb_out_q  <= '0;
            for (int k = 0; k < SECTIONS; k++) begin
                comb_d_q[k] <= '0;
            end
        end else begin
            cur_count_q <= cur_count_d;
            if (in_strobe) begin
                comb_out_q <= comb_res;
                for (int k = 0; k < SECTIONS; k++) begin
                    comb_d_q[k] <= comb_tap[k];
                end
            end
        end
    end

    // Zero-stuffing: the comb result enters the integrators once per low-rate period.
    assign integ[0] = (cur_count_q == CntOne) ? comb_out_q : '0;

    for (genvar k = 1; k <= SECTIONS; k++) begin : g_integ
        cic_integrator_stage #(
            .AccWidth (ACC_WIDTH)
        ) u_stage (
            .clk_i (clk),
            .rst_i (reset),
            .en_i  (clk_enable),
            .in_i  (integ[k-1]),
            .acc_o (integ[k])
        );
    end

    // Output register: truncating bit-slice of the last integrator; ce_out follows the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            filter_out_q <= '0;
            ce_out_q     <= 1'b0;
        end else begin
            ce_out_q <= clk_enable;
            if (clk_enable) begin
                filter_out_q <= integ[SECTIONS][OUT_SHIFT +: OUTPUT_WIDTH];
            end
        end
    end

    assign filter_out = filter_out_q;
    assign ce_out     = ce_out_q;

    // Bits above and below the output window are dropped by design.
    assign unused_integ_bits = ^integ[SECTIONS];

endmodule
